// File: rtl/roce_latency_eval_mq.sv
// Purpose: timestamps RoCEv2 RDMA WRITE packets on TX and retires them against coalesced ACKs on RX, keeping latency stats.
// Latency: ACK on cycle T pops the first covered entry at T+1; its statistics are visible at T+2; one entry retires per cycle after that.
// Backpressure: none. This is a passive observer with no ready outputs; a push into a full FIFO is dropped and flagged sticky.
module roce_latency_eval_mq #(
  parameter int STAMP_WIDTH = 64,
  parameter int DEPTH       = 1024,
  parameter int ACC_WIDTH   = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic                     s_roce_tx_bth_valid,
  input  logic [7:0]               s_roce_tx_bth_op_code,
  input  logic [23:0]              s_roce_tx_bth_psn,
  input  logic                     s_roce_rx_bth_valid,
  input  logic [7:0]               s_roce_rx_bth_op_code,
  input  logic [23:0]              s_roce_rx_bth_psn,
  input  logic                     s_roce_rx_aeth_valid,
  input  logic [7:0]               s_roce_rx_aeth_syndrome,
  output logic [STAMP_WIDTH-1:0]   latency_first_packet,
  output logic [STAMP_WIDTH-1:0]   latency_last_packet,
  output logic [STAMP_WIDTH-1:0]   latency_min,
  output logic [STAMP_WIDTH-1:0]   latency_max,
  output logic [ACC_WIDTH-1:0]     latency_sum,
  output logic [31:0]              msg_count,
  output logic [31:0]              nak_count,
  output logic [STAMP_WIDTH-1:0]   transfer_time_tot,
  output logic [STAMP_WIDTH-1:0]   transfer_time_single,
  output logic                     fifo_overflow,
  output logic [$clog2(DEPTH):0]   outstanding
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [23:0]            psn;
    logic [STAMP_WIDTH-1:0] stamp;
    logic                   is_first;
    logic                   is_last;
  } entry_t;

  typedef enum logic {S_IDLE = 1'b0, S_DRAIN = 1'b1} state_t;

  logic                   start_d_q;
  logic [STAMP_WIDTH-1:0] timer_q;
  logic [AW:0]            wr_ptr_q, rd_ptr_q;
  entry_t                 mem_q [DEPTH];
  logic [23:0]            ack_psn_q;
  logic [STAMP_WIDTH-1:0] ack_time_q;
  logic                   ack_pend_q, ack_pend_d;
  state_t                 state_q, state_d;

  logic [STAMP_WIDTH-1:0] lat_first_q, lat_last_q, lat_min_q, lat_max_q;
  logic [ACC_WIDTH-1:0]   lat_sum_q;
  logic [31:0]            msg_cnt_q, nak_cnt_q;
  logic [STAMP_WIDTH-1:0] tt_tot_q, tt_single_q;
  logic                   ovf_q;

  logic                   start_edge, clr;
  logic                   tx_first, tx_last, tx_store;
  logic                   ack_hit, ack_cap, nak_hit;
  logic [AW:0]            count;
  logic                   empty, full, covered, pop, push_ok, overflow_set;
  logic [23:0]            psn_diff;
  entry_t                 head, new_entry;
  logic [STAMP_WIDTH-1:0] lat;
  logic                   unused_ok;

  assign start_edge = start_i & ~start_d_q;
  assign clr        = ~rst_n | start_edge;

  // FIRST and ONLY open a message; LAST and ONLY close one; MIDDLE is not tracked.
  assign tx_first = (s_roce_tx_bth_op_code == 8'h06) | (s_roce_tx_bth_op_code == 8'h0A) |
                    (s_roce_tx_bth_op_code == 8'h0B);
  assign tx_last  = (s_roce_tx_bth_op_code == 8'h08) | (s_roce_tx_bth_op_code == 8'h09) |
                    (s_roce_tx_bth_op_code == 8'h0A) | (s_roce_tx_bth_op_code == 8'h0B);
  assign tx_store = s_roce_tx_bth_valid & (tx_first | tx_last);

  assign ack_hit = s_roce_rx_bth_valid & s_roce_rx_aeth_valid & (s_roce_rx_bth_op_code == 8'h11);
  assign ack_cap = ack_hit & (s_roce_rx_aeth_syndrome[7:5] == 3'b000);
  assign nak_hit = ack_hit & (s_roce_rx_aeth_syndrome[7:5] == 3'b011);
  assign unused_ok = ^s_roce_rx_aeth_syndrome[4:0];

  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // Serial-number comparison: head is covered when it lies at or behind the ACK PSN
  // within half the 24-bit PSN space, which makes the 0xFFFFFF -> 0 wrap transparent.
  assign psn_diff = ack_psn_q - head.psn;
  assign covered  = ~psn_diff[23];
  assign lat      = ack_time_q - head.stamp;

  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands then.
  assign push_ok      = tx_store & (~full | pop);
  assign overflow_set = tx_store & full & ~pop;

  assign new_entry = '{psn: s_roce_tx_bth_psn, stamp: timer_q, is_first: tx_first, is_last: tx_last};

  // Start-edge detector register.
  always_ff @(posedge clk) begin
    if (!rst_n) start_d_q <= 1'b0;
    else        start_d_q <= start_i;
  end

  // Free-running timestamp counter, restarted by reset or a start edge.
  always_ff @(posedge clk) begin
    if (clr) timer_q <= '0;
    else     timer_q <= timer_q + STAMP_WIDTH'(1);
  end

  // Entry storage; pointers alone define validity, so the array needs no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= new_entry;
  end

  // FIFO pointers and the captured ACK registers; a newer ACK overwrites an older one.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ack_psn_q  <= '0;
      ack_time_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      if (ack_cap) begin
        ack_psn_q  <= s_roce_rx_bth_psn;
        ack_time_q <= timer_q;
      end
    end
  end

  // Drain FSM state register.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= S_IDLE;
      ack_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_pend_q <= ack_pend_d;
    end
  end

  // Drain FSM next state: pop covered heads one per cycle, return to idle when none is left.
  // Entering DRAIN together with the capture lets the first pop use the ACK the next cycle.
  always_comb begin
    state_d    = state_q;
    ack_pend_d = ack_pend_q | ack_cap;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ack_pend_q || ack_cap) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!empty && covered) begin
          pop = 1'b1;
        end else begin
          ack_pend_d = ack_cap;
          state_d    = ack_cap ? S_DRAIN : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Retirement statistics, NAK count and sticky overflow.
  always_ff @(posedge clk) begin
    if (clr) begin
      lat_first_q <= '0;
      lat_last_q  <= '0;
      lat_min_q   <= '1;
      lat_max_q   <= '0;
      lat_sum_q   <= '0;
      msg_cnt_q   <= '0;
      nak_cnt_q   <= '0;
      tt_tot_q    <= '0;
      tt_single_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      if (nak_hit)      nak_cnt_q <= nak_cnt_q + 32'd1;
      if (overflow_set) ovf_q     <= 1'b1;
      if (pop && head.is_first) lat_first_q <= lat;
      if (pop && head.is_last) begin
        lat_last_q  <= lat;
        if (lat < lat_min_q) lat_min_q <= lat;
        if (lat > lat_max_q) lat_max_q <= lat;
        lat_sum_q   <= lat_sum_q + ACC_WIDTH'(lat);
        msg_cnt_q   <= msg_cnt_q + 32'd1;
        tt_single_q <= ack_time_q - tt_tot_q;
        tt_tot_q    <= ack_time_q;
      end
    end
  end

  assign latency_first_packet = lat_first_q;
  assign latency_last_packet  = lat_last_q;
  assign latency_min          = lat_min_q;
  assign latency_max          = lat_max_q;
  assign latency_sum          = lat_sum_q;
  assign msg_count            = msg_cnt_q;
  assign nak_count            = nak_cnt_q;
  assign transfer_time_tot    = tt_tot_q;
  assign transfer_time_single = tt_single_q;
  assign fifo_overflow        = ovf_q;
  assign outstanding          = count;

endmodule

// File: tb/tb_roce_latency_eval_mq.sv
// Purpose: scoreboard bench for roce_latency_eval_mq with a four-entry FIFO.
// Latency: expected retirements are queued when an ACK is driven and checked when outstanding drops.
// Backpressure: none; the design never stalls its inputs.
module tb_roce_latency_eval_mq;

  localparam int SW    = 64;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [63:0] ONES = '1;

  logic          clk = 1'b0;
  logic          rst_n, start_i;
  logic          tx_vld, rx_vld, aeth_vld;
  logic [7:0]    tx_op, rx_op, syn;
  logic [23:0]   tx_psn, rx_psn;
  logic [SW-1:0] lat_first, lat_last, lat_min, lat_max, tt_tot, tt_single;
  logic [63:0]   lat_sum;
  logic [31:0]   msg_count, nak_count;
  logic          fifo_overflow;
  logic [AW:0]   outstanding;

  roce_latency_eval_mq #(.STAMP_WIDTH(SW), .DEPTH(DEPTH), .ACC_WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
    .s_roce_tx_bth_valid(tx_vld), .s_roce_tx_bth_op_code(tx_op), .s_roce_tx_bth_psn(tx_psn),
    .s_roce_rx_bth_valid(rx_vld), .s_roce_rx_bth_op_code(rx_op), .s_roce_rx_bth_psn(rx_psn),
    .s_roce_rx_aeth_valid(aeth_vld), .s_roce_rx_aeth_syndrome(syn),
    .latency_first_packet(lat_first), .latency_last_packet(lat_last),
    .latency_min(lat_min), .latency_max(lat_max), .latency_sum(lat_sum),
    .msg_count(msg_count), .nak_count(nak_count),
    .transfer_time_tot(tt_tot), .transfer_time_single(tt_single),
    .fifo_overflow(fifo_overflow), .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  typedef struct { logic [23:0] psn; logic [63:0] stamp; bit f; bit l; } ment_t;
  typedef struct { bit f; bit l; logic [63:0] lat; logic [63:0] at; } exp_t;

  ment_t m_fifo[$];
  exp_t  exp_q[$];
  logic [63:0] e_first, e_last, e_min, e_max, e_sum, e_tot, e_single;
  logic [31:0] e_msg, e_nak;
  bit          e_ovf;

  int n_chk  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;
  int prev_out = 0;

  logic [63:0] tb_timer;
  logic        tb_start_d;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference timer: cleared by reset and by a rising edge of start_i, else counts.
  always @(posedge clk) begin
    if (!rst_n) begin
      tb_timer   <= '0;
      tb_start_d <= 1'b0;
    end else begin
      tb_start_d <= start_i;
      tb_timer   <= (start_i && !tb_start_d) ? 64'd0 : tb_timer + 64'd1;
    end
  end

  // Retirement monitor: each drop in occupancy is one retired entry.
  always @(negedge clk) begin
    exp_t r;
    if (mon_en && int'(outstanding) < prev_out) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", 64'(outstanding), 64'(prev_out));
      end else begin
        r = exp_q.pop_front();
        if (r.f) chk("ret_lat_first", lat_first, r.lat);
        if (r.l) begin
          chk("ret_lat_last", lat_last, r.lat);
          chk("ret_tt_tot", tt_tot, r.at);
        end
      end
    end
    prev_out = int'(outstanding);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_fifo.delete();
    exp_q.delete();
    e_first = '0; e_last = '0; e_min = ONES; e_max = '0; e_sum = '0;
    e_tot = '0; e_single = '0; e_msg = '0; e_nak = '0; e_ovf = 1'b0;
  endtask

  task automatic drive_tx(input logic [7:0] op, input logic [23:0] psn);
    ment_t m;
    bit f, l;
    f = (op == 8'h06) || (op == 8'h0A) || (op == 8'h0B);
    l = (op == 8'h08) || (op == 8'h09) || (op == 8'h0A) || (op == 8'h0B);
    if (f || l) begin
      if (m_fifo.size() < DEPTH) begin
        m = '{psn: psn, stamp: tb_timer, f: f, l: l};
        m_fifo.push_back(m);
      end else begin
        e_ovf = 1'b1;
      end
    end
    tx_vld = 1'b1; tx_op = op; tx_psn = psn;
    tick();
    tx_vld = 1'b0;
  endtask

  task automatic drive_ack(input logic [7:0] s, input logic [23:0] psn);
    logic [23:0] d;
    logic [63:0] l;
    ment_t m;
    exp_t r;
    if (s[7:5] == 3'b011) e_nak = e_nak + 32'd1;
    if (s[7:5] == 3'b000) begin
      while (m_fifo.size() > 0) begin
        d = psn - m_fifo[0].psn;
        if (d[23]) break;
        m = m_fifo.pop_front();
        l = tb_timer - m.stamp;
        r = '{f: m.f, l: m.l, lat: l, at: tb_timer};
        exp_q.push_back(r);
        if (m.f) e_first = l;
        if (m.l) begin
          e_last = l;
          if (l < e_min) e_min = l;
          if (l > e_max) e_max = l;
          e_sum = e_sum + l;
          e_msg = e_msg + 32'd1;
          e_single = tb_timer - e_tot;
          e_tot = tb_timer;
        end
      end
    end
    rx_vld = 1'b1; aeth_vld = 1'b1; rx_op = 8'h11; rx_psn = psn; syn = s;
    tick();
    rx_vld = 1'b0; aeth_vld = 1'b0;
  endtask

  task automatic do_start();
    mon_en = 1'b0;
    model_clear();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic wait_timer(input logic [63:0] v);
    int n = 0;
    while (tb_timer != v && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("wait_timer_timeout", tb_timer, v);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_stats(input string tag);
    chk({tag, "_lat_first"}, lat_first, e_first);
    chk({tag, "_lat_last"},  lat_last,  e_last);
    chk({tag, "_lat_min"},   lat_min,   e_min);
    chk({tag, "_lat_max"},   lat_max,   e_max);
    chk({tag, "_lat_sum"},   lat_sum,   e_sum);
    chk({tag, "_msg"},       64'(msg_count), 64'(e_msg));
    chk({tag, "_nak"},       64'(nak_count), 64'(e_nak));
    chk({tag, "_tt_tot"},    tt_tot,    e_tot);
    chk({tag, "_tt_single"}, tt_single, e_single);
    chk({tag, "_ovf"},       64'(fifo_overflow), 64'(e_ovf));
    chk({tag, "_outst"},     64'(outstanding), 64'(m_fifo.size()));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start_i = 1'b0;
    tx_vld = 1'b0; tx_op = '0; tx_psn = '0;
    rx_vld = 1'b0; aeth_vld = 1'b0; rx_op = '0; rx_psn = '0; syn = '0;
    model_clear();
    repeat (3) tick();
    rst_n = 1'b1;
    mon_en = 1'b1;
    check_stats("reset");

    // Single ONLY message, stamp 10, ACK at 25: retire timing T+1 pop, T+2 visible.
    do_start();
    wait_timer(64'd10);
    drive_tx(8'h0A, 24'd5);
    wait_timer(64'd25);
    drive_ack(8'h00, 24'd5);
    chk("t1_not_yet_msg", 64'(msg_count), 64'd0);
    tick();
    chk("t1_visible_msg", 64'(msg_count), 64'd1);
    wait_drain();
    chk("t1_lat_last_15", lat_last, 64'd15);
    chk("t1_lat_first_15", lat_first, 64'd15);
    chk("t1_tt_tot_25", tt_tot, 64'd25);
    check_stats("t1");

    // FIRST/MIDDLE/LAST with one coalesced ACK.
    do_start();
    wait_timer(64'd10);
    drive_tx(8'h06, 24'd0);
    drive_tx(8'h07, 24'd1);
    wait_timer(64'd14);
    drive_tx(8'h08, 24'd2);
    wait_timer(64'd40);
    drive_ack(8'h00, 24'd2);
    chk("t2_outst_T1", 64'(outstanding), 64'd2);
    tick();
    chk("t2_outst_T2", 64'(outstanding), 64'd1);
    tick();
    chk("t2_outst_T3", 64'(outstanding), 64'd0);
    wait_drain();
    chk("t2_lat_first_30", lat_first, 64'd30);
    chk("t2_lat_last_26", lat_last, 64'd26);
    chk("t2_msg_1", 64'(msg_count), 64'd1);
    check_stats("t2");

    // PSN wrap: ACK behind the window retires nothing, ACK 0 retires all three.
    do_start();
    drive_tx(8'h0A, 24'hFFFFFE);
    drive_tx(8'h0A, 24'hFFFFFF);
    drive_tx(8'h0A, 24'h000000);
    drive_ack(8'h00, 24'hFFFFFD);
    repeat (3) tick();
    chk("t3_none_outst", 64'(outstanding), 64'd3);
    chk("t3_none_msg", 64'(msg_count), 64'd0);
    drive_ack(8'h00, 24'h000000);
    wait_drain();
    chk("t3_msg_3", 64'(msg_count), 64'd3);
    check_stats("t3");

    // NAK counts without retiring; a later ACK retires.
    do_start();
    drive_tx(8'h0A, 24'd7);
    drive_ack(8'h60, 24'd7);
    repeat (2) tick();
    chk("t4_nak_1", 64'(nak_count), 64'd1);
    chk("t4_outst_1", 64'(outstanding), 64'd1);
    drive_ack(8'h00, 24'd7);
    wait_drain();
    chk("t4_outst_0", 64'(outstanding), 64'd0);
    check_stats("t4");

    // Overflow on a four-entry FIFO, then a start edge clears everything.
    for (int i = 0; i < 5; i++) drive_tx(8'h0A, 24'(20 + i));
    tick();
    chk("t5_outst_4", 64'(outstanding), 64'd4);
    chk("t5_ovf_1", 64'(fifo_overflow), 64'd1);
    check_stats("t5");
    do_start();
    tick();
    chk("t5_start_ovf", 64'(fifo_overflow), 64'd0);
    chk("t5_start_min", lat_min, ONES);
    check_stats("t5_start");

    // Reset pulse in the middle of a drain stops further pops.
    drive_tx(8'h0A, 24'd1);
    drive_tx(8'h0A, 24'd2);
    drive_tx(8'h0A, 24'd3);
    drive_ack(8'h00, 24'd3);
    tick();
    chk("t6_first_retire", 64'(msg_count), 64'd1);
    mon_en = 1'b0;
    model_clear();
    rst_n = 1'b0;
    tick();
    check_stats("t6_rst");
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (3) tick();
    chk("t6_no_pop_outst", 64'(outstanding), 64'd0);
    chk("t6_no_pop_msg", 64'(msg_count), 64'd0);
    chk("t6_no_pop_lat", lat_last, 64'd0);

    chk("final_exp_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/roce_latency_eval_mq.md
# roce_latency_eval_mq

Parametrised RoCEv2 latency/throughput evaluator that timestamps outgoing RDMA WRITE packets on the TX header path and retires them against (possibly coalesced) ACKs on the RX header path. It sits beside the RoCE TX/RX header pipelines as a passive observer and never back-pressures either path. It extends single-message latency capture with configurable timer width and depth, coalesced-ACK retirement with 24-bit PSN wrap, NAK counting, min/max/sum statistics and overflow detection.

## Interface
- STAMP_WIDTH, 64: free-running timer and all time outputs width.
- DEPTH, 1024: outstanding-entry FIFO depth (power of two, ≥4).
- ACC_WIDTH, 64: latency accumulator width (≥ STAMP_WIDTH).
- clk  in  1  sole clock.
- rst_n  in  1  reset, synchronous, active-low.
- start_i  in  1  rising edge starts a new measurement run.
- s_roce_tx_bth_valid  in  1  TX BTH header beat.
- s_roce_tx_bth_op_code  in  8  TX opcode.
- s_roce_tx_bth_psn  in  24  TX PSN.
- s_roce_rx_bth_valid  in  1  RX BTH header beat.
- s_roce_rx_bth_op_code  in  8  RX opcode.
- s_roce_rx_bth_psn  in  24  RX PSN.
- s_roce_rx_aeth_valid  in  1  RX AETH present.
- s_roce_rx_aeth_syndrome  in  8  AETH syndrome.
- latency_first_packet  out  STAMP_WIDTH  latency of most recently retired FIRST/ONLY entry.
- latency_last_packet  out  STAMP_WIDTH  latency of most recently retired LAST/ONLY entry.
- latency_min / latency_max  out  STAMP_WIDTH  extremes over retired LAST/ONLY entries.
- latency_sum  out  ACC_WIDTH  sum over retired LAST/ONLY entries, wraps modulo 2^ACC_WIDTH.
- msg_count  out  32  retired LAST/ONLY entries, wraps.
- nak_count  out  32  NAKs seen, wraps.
- transfer_time_tot  out  STAMP_WIDTH  ACK time of latest retired LAST/ONLY entry.
- transfer_time_single  out  STAMP_WIDTH  difference between last two transfer_time_tot values.
- fifo_overflow  out  1  sticky: an entry was dropped.
- outstanding  out  clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Opcodes: FIRST 0x06, MIDDLE 0x07, LAST 0x08, LAST_IMD 0x09, ONLY 0x0A, ONLY_IMD 0x0B, ACK 0x11.
- Timer: increments every cycle; cleared to 0 on reset and on start edge (start_i & ~start_d, start_d registered, reset to 0).
- Push: on tx_bth_valid with FIRST/LAST/LAST_IMD/ONLY/ONLY_IMD, write {psn, timer, is_first, is_last} (ONLY sets both). MIDDLE and other opcodes not stored.
- Full: push while full and no pop in same cycle → entry dropped, fifo_overflow set. Push and pop in same cycle both proceed.
- ACK capture: rx_bth_valid & rx_aeth_valid & op_code==0x11:
  - syndrome[7:5]==000: ack_psn←rx psn, ack_time←timer, ack_pend←1. A later ACK overwrites both registers, including mid-drain.
  - syndrome[7:5]==011: nak_count+1; no retirement.
  - other syndromes ignored.
- Drain FSM, IDLE/DRAIN: IDLE→DRAIN when ack_pend. In DRAIN, each cycle, if FIFO non-empty and head covered, pop one entry; else →IDLE and clear ack_pend (unless a new ACK is captured that cycle, which keeps ack_pend set).
- Covered: ((ack_psn − head_psn) mod 2^24) < 2^23, so PSN wrap 0xFFFFFF→0x000000 is handled.
- Retire, lat = ack_time − stamp (mod 2^STAMP_WIDTH):
  - is_first: latency_first_packet←lat.
  - is_last: latency_last_packet←lat; min/max update; sum+=lat; msg_count+1; transfer_time_single←ack_time − transfer_time_tot; transfer_time_tot←ack_time.
- Start edge: flushes FIFO, clears ack_pend, FSM→IDLE, all outputs to reset values. Takes priority over simultaneous push/ACK.

## Timing
- Reset/start values: all outputs 0 except latency_min = all ones; fifo_overflow 0; outstanding 0.
- ACK on cycle T → ack registers valid T+1 → first pop T+1 → statistics visible T+2; subsequent coalesced entries retire one per cycle.
- Push on cycle T → outstanding increments at T+1.
- No ready outputs; inputs are never stalled.

## Test plan
- Single ONLY at timer 10, psn 5; ACK psn 5 at timer 25 → latency_first=latency_last=15, msg_count 1, min=max=15, transfer_time_tot 25.
- FIRST psn 0 @10, MIDDLE psn 1, LAST psn 2 @14; one ACK psn 2 @40 → two retirements on consecutive cycles, latency_first 30, latency_last 26, outstanding 0.
- Three ONLY messages, psn 0xFFFFFE, 0xFFFFFF, 0x000000; ACK psn 0x000000 → all three retired, msg_count 3; ACK psn 0xFFFFFD retires none.
- NAK (syndrome 0x60) for pending psn → nak_count 1, outstanding unchanged; subsequent ACK retires entry.
- DEPTH=4, push 5 ONLY without ACKs → outstanding 4, fifo_overflow 1; start edge → overflow 0, outstanding 0, latency_min all ones.
- rst_n low mid-DRAIN for one cycle → all outputs at reset values next cycle, no further pops.
